// File: rtl/ac_pkg.sv
// Shared types for the AC pulse driver: FSM state encoding, side encodings and a
// small constant helper used to size the phase counter.
package ac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        PULSE,
        HOLD,
        CHECK
    } state_t;

    localparam logic SIDE_LEFT  = 1'b0;
    localparam logic SIDE_RIGHT = 1'b1;

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/ac_pulse_driver_if.sv
// Command handshake into the pulse driver: valid/ready with a one-bit target state.
// The driver is the slave; ready is only high while the driver is idle.
interface ac_pulse_driver_if;
    logic valid;
    logic ready;
    logic target;

    modport master (output valid, output target, input ready);
    modport slave  (input valid, input target, output ready);
endinterface

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for one asynchronous level; STAGES cycles of latency.
// No backpressure; cleared to 0 by reset_left.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_left,
    input  logic async_bit,
    output logic sync_bit
);

    logic [STAGES-1:0] chain;

    always_ff @(posedge clk or posedge reset_left) begin
        if (reset_left) begin
            chain <= '0;
        end else begin
            chain <= {chain[STAGES-2:0], async_bit};
        end
    end

    assign sync_bit = chain[STAGES-1];

endmodule

// File: rtl/ac_pulse_driver.sv
// Sequences gate + AC-set pulse on one side of a bistable, then confirms b via a synchronizer.
// All outputs registered; ready only in IDLE, so commands stall while a sequence is in flight.
module ac_pulse_driver
    import ac_pkg::*;
#(
    parameter int SETUP_CYCLES = 2,
    parameter int PULSE_CYCLES = 1,
    parameter int HOLD_CYCLES  = 1,
    parameter int CHECK_CYCLES = 8,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset_left,
    ac_pulse_driver_if.slave     req,
    input  logic                 ff_b,
    output logic                 gate_left,
    output logic                 ac_set_left,
    output logic                 gate_right,
    output logic                 ac_set_right,
    output logic                 busy,
    output logic                 done,
    output logic                 done_err,
    output logic                 done_noop
);

    localparam int CW = $clog2(max4(SETUP_CYCLES, PULSE_CYCLES, HOLD_CYCLES, CHECK_CYCLES) + 1);

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          tgt, tgt_nxt;
    logic          b_sync;
    logic          done_nxt, err_nxt, noop_nxt;
    logic          active_nxt;

    bit_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk        (clk),
        .reset_left (reset_left),
        .async_bit  (ff_b),
        .sync_bit   (b_sync)
    );

    always_ff @(posedge clk or posedge reset_left) begin
        if (reset_left) begin
            state        <= IDLE;
            cnt          <= '0;
            tgt          <= SIDE_LEFT;
            req.ready    <= 1'b1;
            busy         <= 1'b0;
            done         <= 1'b0;
            done_err     <= 1'b0;
            done_noop    <= 1'b0;
            gate_left    <= 1'b0;
            ac_set_left  <= 1'b0;
            gate_right   <= 1'b0;
            ac_set_right <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            tgt          <= tgt_nxt;
            req.ready    <= (state_nxt == IDLE);
            busy         <= (state_nxt != IDLE);
            done         <= done_nxt;
            done_err     <= err_nxt;
            done_noop    <= noop_nxt;
            // Outputs decode the next state so gate and pulse are clean flop outputs.
            gate_left    <= active_nxt && (tgt_nxt == SIDE_LEFT);
            ac_set_left  <= (state_nxt == PULSE) && (tgt_nxt == SIDE_LEFT);
            gate_right   <= active_nxt && (tgt_nxt == SIDE_RIGHT);
            ac_set_right <= (state_nxt == PULSE) && (tgt_nxt == SIDE_RIGHT);
        end
    end

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        tgt_nxt    = tgt;
        done_nxt   = 1'b0;
        err_nxt    = 1'b0;
        noop_nxt   = 1'b0;
        active_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (req.valid) begin
                    tgt_nxt = req.target;
                    if (b_sync == req.target) begin
                        done_nxt = 1'b1;
                        noop_nxt = 1'b1;
                    end else begin
                        state_nxt = SETUP;
                        cnt_nxt   = CW'(SETUP_CYCLES - 1);
                    end
                end
            end
            SETUP: begin
                if (cnt == '0) begin
                    state_nxt = PULSE;
                    cnt_nxt   = CW'(PULSE_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            PULSE: begin
                if (cnt == '0) begin
                    state_nxt = HOLD;
                    cnt_nxt   = CW'(HOLD_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            HOLD: begin
                if (cnt == '0) begin
                    state_nxt = CHECK;
                    cnt_nxt   = CW'(CHECK_CYCLES - 1);
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            CHECK: begin
                if (b_sync == tgt) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                end else if (cnt == '0) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                    done_nxt  = 1'b1;
                    err_nxt   = 1'b1;
                end else begin
                    cnt_nxt = cnt - CW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        active_nxt = (state_nxt == SETUP) || (state_nxt == PULSE) || (state_nxt == HOLD);
    end

endmodule
